// File: rtl/palette_pkg.sv
// Shared types and helpers for the palette lookup block: RGB word type,
// loader state encoding and the greyscale ramp used as reset contents.
package palette_pkg;

   localparam int CH_W  = 8;
   localparam int RGB_W = 3 * CH_W;

   typedef logic [RGB_W-1:0] rgb_t;

   typedef enum logic {
      LD_IDLE = 1'b0,
      LD_LOAD = 1'b1
   } ld_state_e;

   // Entry i of a 2**idx_w palette: equal R/G/B stepping linearly from black to white.
   function automatic rgb_t grey_ramp(input int i, input int idx_w);
      int              maxIdx;
      logic [CH_W-1:0] grey;
      maxIdx = (1 << idx_w) - 1;
      grey   = CH_W'((i * 255) / maxIdx);
      return {3{grey}};
   endfunction

endpackage

// File: rtl/palette_loader.sv
// Shadow-palette loader: walks the word counter for the palette being filled
// and tracks which complete shadows are waiting for the next frame boundary.
module palette_loader
   import palette_pkg::*;
#(
   parameter int IDX_W   = 4,
   parameter int COLOR_W = 24,
   parameter int NUM_PAL = 4,
   parameter int PAL_W   = 2
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ld_start,
   input  logic [PAL_W-1:0]   i_ld_pal,
   input  logic               i_ld_valid,
   input  logic [COLOR_W-1:0] i_ld_data,
   input  logic               i_frame_start,
   output logic               o_ld_ready,
   output logic               o_ld_busy,
   output logic [NUM_PAL-1:0] o_pending,
   output logic               o_wr_en,
   output logic [PAL_W-1:0]   o_wr_pal,
   output logic [IDX_W-1:0]   o_wr_addr,
   output logic [COLOR_W-1:0] o_wr_data
);

   localparam logic [IDX_W-1:0] LAST_IDX = '1;

   ld_state_e          state_q,   state_d;
   logic [IDX_W-1:0]   cnt_q,     cnt_d;
   logic [PAL_W-1:0]   pal_q,     pal_d;
   logic [NUM_PAL-1:0] pending_q, pending_d;
   logic               wrEn;

   // A restart takes priority over a word presented in the same cycle, so an
   // interrupted load never marks either palette pending.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pal_d     = pal_q;
      pending_d = pending_q;
      wrEn      = 1'b0;

      if (i_frame_start) begin
         pending_d = '0;
      end

      if (i_ld_start) begin
         state_d = LD_LOAD;
         cnt_d   = '0;
         pal_d   = i_ld_pal;
         for (int p = 0; p < NUM_PAL; p++) begin
            if (PAL_W'(p) == i_ld_pal) begin
               pending_d[p] = 1'b0;
            end
         end
      end else if ((state_q == LD_LOAD) && i_ld_valid) begin
         wrEn  = 1'b1;
         cnt_d = cnt_q + IDX_W'(1);
         if (cnt_q == LAST_IDX) begin
            state_d = LD_IDLE;
            for (int p = 0; p < NUM_PAL; p++) begin
               if (PAL_W'(p) == pal_q) begin
                  pending_d[p] = 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q   <= LD_IDLE;
         cnt_q     <= '0;
         pal_q     <= '0;
         pending_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pal_q     <= pal_d;
         pending_q <= pending_d;
      end
   end

   assign o_ld_ready = (state_q == LD_LOAD);
   assign o_ld_busy  = (state_q == LD_LOAD);
   assign o_pending  = pending_q;
   assign o_wr_en    = wrEn;
   assign o_wr_pal   = pal_q;
   assign o_wr_addr  = cnt_q;
   assign o_wr_data  = i_ld_data;

endmodule

// File: rtl/palette_lut.sv
// Multi-palette colour lookup with double-buffered palettes: shadows are filled
// by the loader and copied into the active set only at a frame boundary.
module palette_lut
   import palette_pkg::*;
#(
   parameter  int IDX_W     = 4,
   parameter  int COLOR_W   = 24,
   parameter  int NUM_PAL   = 4,
   parameter  int TRANSP_EN = 1,
   localparam int PAL_W     = (NUM_PAL > 1) ? $clog2(NUM_PAL) : 1
) (
   input  logic               i_clk,
   input  logic               i_rst_n,
   input  logic               i_ld_start,
   input  logic [PAL_W-1:0]   i_ld_pal,
   input  logic               i_ld_valid,
   input  logic [COLOR_W-1:0] i_ld_data,
   output logic               o_ld_ready,
   output logic               o_ld_busy,
   output logic [NUM_PAL-1:0] o_pending,
   input  logic               i_frame_start,
   input  logic               i_px_valid,
   input  logic [PAL_W-1:0]   i_pal_sel,
   input  logic [IDX_W-1:0]   i_idx,
   output logic               o_px_valid,
   output logic [COLOR_W-1:0] o_rgb,
   output logic               o_transparent
);

   localparam int DEPTH = 2 ** IDX_W;

   logic [COLOR_W-1:0] active_q [NUM_PAL][DEPTH];
   logic [COLOR_W-1:0] shadow_q [NUM_PAL][DEPTH];

   logic               wrEn;
   logic [PAL_W-1:0]   wrPal;
   logic [IDX_W-1:0]   wrAddr;
   logic [COLOR_W-1:0] wrData;
   logic [NUM_PAL-1:0] pending;

   logic               s1Valid_q;
   logic [PAL_W-1:0]   s1Pal_q;
   logic [IDX_W-1:0]   s1Idx_q;
   logic               s2Valid_q;
   logic [COLOR_W-1:0] rgb_q;
   logic               transp_q;

   logic [COLOR_W-1:0] rdRgb;
   logic               rdPalOk;
   logic               rdTransp;

   palette_loader #(
      .IDX_W   (IDX_W),
      .COLOR_W (COLOR_W),
      .NUM_PAL (NUM_PAL),
      .PAL_W   (PAL_W)
   ) u_loader (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_ld_start    (i_ld_start),
      .i_ld_pal      (i_ld_pal),
      .i_ld_valid    (i_ld_valid),
      .i_ld_data     (i_ld_data),
      .i_frame_start (i_frame_start),
      .o_ld_ready    (o_ld_ready),
      .o_ld_busy     (o_ld_busy),
      .o_pending     (pending),
      .o_wr_en       (wrEn),
      .o_wr_pal      (wrPal),
      .o_wr_addr     (wrAddr),
      .o_wr_data     (wrData)
   );

   assign o_pending = pending;

   // Commit uses the registered pending bits, so a shadow completed on the
   // same edge as the frame pulse waits for the following frame.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int p = 0; p < NUM_PAL; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
               active_q[p][i] <= COLOR_W'(grey_ramp(i, IDX_W));
            end
         end
      end else if (i_frame_start) begin
         for (int p = 0; p < NUM_PAL; p++) begin
            if (pending[p]) begin
               for (int i = 0; i < DEPTH; i++) begin
                  active_q[p][i] <= shadow_q[p][i];
               end
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int p = 0; p < NUM_PAL; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
               shadow_q[p][i] <= COLOR_W'(grey_ramp(i, IDX_W));
            end
         end
      end else if (wrEn) begin
         for (int p = 0; p < NUM_PAL; p++) begin
            if (wrPal == PAL_W'(p)) begin
               shadow_q[p][wrAddr] <= wrData;
            end
         end
      end
   end

   // Palette selects beyond NUM_PAL read as transparent black.
   always_comb begin
      rdRgb   = '0;
      rdPalOk = 1'b0;
      for (int p = 0; p < NUM_PAL; p++) begin
         if (s1Pal_q == PAL_W'(p)) begin
            rdRgb   = active_q[p][s1Idx_q];
            rdPalOk = 1'b1;
         end
      end
      rdTransp = !rdPalOk || ((TRANSP_EN != 0) && (s1Idx_q == '0));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         s1Valid_q <= 1'b0;
         s1Pal_q   <= '0;
         s1Idx_q   <= '0;
         s2Valid_q <= 1'b0;
         rgb_q     <= '0;
         transp_q  <= 1'b0;
      end else begin
         s1Valid_q <= i_px_valid;
         s1Pal_q   <= i_pal_sel;
         s1Idx_q   <= i_idx;
         s2Valid_q <= s1Valid_q;
         if (s1Valid_q) begin
            rgb_q    <= rdRgb;
            transp_q <= rdTransp;
         end
      end
   end

   assign o_px_valid    = s2Valid_q;
   assign o_rgb         = rgb_q;
   assign o_transparent = transp_q;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: lookups are scoreboarded against
// expected colours, loader/commit status is checked at fixed points.
module tb_palette_lut;

   logic        i_clk = 1'b0;
   logic        i_rst_n;
   logic        i_ld_start;
   logic [1:0]  i_ld_pal;
   logic        i_ld_valid;
   logic [23:0] i_ld_data;
   logic        o_ld_ready;
   logic        o_ld_busy;
   logic [3:0]  o_pending;
   logic        i_frame_start;
   logic        i_px_valid;
   logic [1:0]  i_pal_sel;
   logic [3:0]  i_idx;
   logic        o_px_valid;
   logic [23:0] o_rgb;
   logic        o_transparent;

   int          numChecks = 0;
   int          numErrors = 0;
   logic [24:0] expQ[$];
   logic [24:0] monExp;
   int          runLen  = 0;
   int          lastRun = 0;

   palette_lut dut (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_ld_start    (i_ld_start),
      .i_ld_pal      (i_ld_pal),
      .i_ld_valid    (i_ld_valid),
      .i_ld_data     (i_ld_data),
      .o_ld_ready    (o_ld_ready),
      .o_ld_busy     (o_ld_busy),
      .o_pending     (o_pending),
      .i_frame_start (i_frame_start),
      .i_px_valid    (i_px_valid),
      .i_pal_sel     (i_pal_sel),
      .i_idx         (i_idx),
      .o_px_valid    (o_px_valid),
      .o_rgb         (o_rgb),
      .o_transparent (o_transparent)
   );

   always #5 i_clk = ~i_clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      numChecks++;
      if (obs !== exp) begin
         numErrors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [23:0] ramp(input int i);
      logic [7:0] g;
      g = 8'((i * 255) / 15);
      return {g, g, g};
   endfunction

   task automatic applyStimulus(input logic [1:0] pal, input logic [3:0] idx,
                                input logic [23:0] expRgb, input logic expT);
      i_px_valid = 1'b1;
      i_pal_sel  = pal;
      i_idx      = idx;
      expQ.push_back({expRgb, expT});
      @(negedge i_clk);
   endtask

   task automatic drainPx();
      int guard = 0;
      while (expQ.size() != 0 && guard < 20) begin
         @(negedge i_clk);
         guard++;
      end
      checkOutput("drain", 32'(expQ.size()), 32'd0);
      repeat (2) @(negedge i_clk);
   endtask

   task automatic startLoad(input logic [1:0] pal);
      i_ld_start = 1'b1;
      i_ld_pal   = pal;
      @(negedge i_clk);
      i_ld_start = 1'b0;
   endtask

   task automatic sendWords(input logic [23:0] base, input int first, input int count,
                            input bit frameAtLast, input bit randomValid);
      int n     = 0;
      int guard = 0;
      while (n < count && guard < 400) begin
         i_ld_valid    = randomValid ? 1'($urandom_range(0, 1)) : 1'b1;
         i_ld_data     = base + 24'(first + n);
         i_frame_start = frameAtLast && i_ld_valid && (n == count - 1);
         if (i_ld_valid) n++;
         guard++;
         @(negedge i_clk);
      end
      i_ld_valid    = 1'b0;
      i_frame_start = 1'b0;
      checkOutput("ldWords", 32'(n), 32'(count));
   endtask

   task automatic pulseFrame();
      i_frame_start = 1'b1;
      @(negedge i_clk);
      i_frame_start = 1'b0;
   endtask

   always @(negedge i_clk) begin
      if (o_px_valid) begin
         runLen++;
         if (expQ.size() == 0) begin
            checkOutput("pxUnexpected", 32'd1, 32'd0);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("pxRgb", 32'(o_rgb), 32'(monExp[24:1]));
            checkOutput("pxTransp", 32'(o_transparent), 32'(monExp[0]));
         end
      end else begin
         if (runLen != 0) lastRun = runLen;
         runLen = 0;
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time 400000, expected finish earlier");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      i_rst_n       = 1'b0;
      i_ld_start    = 1'b0;
      i_ld_pal      = 2'd0;
      i_ld_valid    = 1'b0;
      i_ld_data     = 24'd0;
      i_frame_start = 1'b0;
      i_px_valid    = 1'b0;
      i_pal_sel     = 2'd0;
      i_idx         = 4'd0;
      repeat (3) @(negedge i_clk);

      checkOutput("rstPxValid", 32'(o_px_valid), 32'd0);
      checkOutput("rstRgb", 32'(o_rgb), 32'd0);
      checkOutput("rstTransp", 32'(o_transparent), 32'd0);
      checkOutput("rstPending", 32'(o_pending), 32'd0);
      checkOutput("rstBusy", 32'(o_ld_busy), 32'd0);
      checkOutput("rstReady", 32'(o_ld_ready), 32'd0);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Default ramp and two-cycle latency
      applyStimulus(2'd0, 4'd15, 24'hffffff, 1'b0);
      i_px_valid = 1'b0;
      checkOutput("lat1", 32'(o_px_valid), 32'd0);
      @(negedge i_clk);
      checkOutput("lat2", 32'(o_px_valid), 32'd1);
      applyStimulus(2'd0, 4'd0, 24'h000000, 1'b1);
      i_px_valid = 1'b0;
      drainPx();

      // Load palette 2, commit on the frame pulse
      startLoad(2'd2);
      checkOutput("busyLoad", 32'(o_ld_busy), 32'd1);
      checkOutput("readyLoad", 32'(o_ld_ready), 32'd1);
      sendWords(24'h100000, 0, 8, 1'b0, 1'b0);
      checkOutput("busyMid", 32'(o_ld_busy), 32'd1);
      sendWords(24'h100000, 8, 8, 1'b0, 1'b0);
      checkOutput("busyDone", 32'(o_ld_busy), 32'd0);
      checkOutput("readyDone", 32'(o_ld_ready), 32'd0);
      checkOutput("pend2", 32'(o_pending), 32'h4);
      applyStimulus(2'd2, 4'd5, 24'h555555, 1'b0);
      i_px_valid = 1'b0;
      drainPx();
      i_frame_start = 1'b1;
      applyStimulus(2'd2, 4'd5, 24'h100005, 1'b0);
      i_frame_start = 1'b0;
      checkOutput("pend2Clr", 32'(o_pending), 32'd0);
      applyStimulus(2'd2, 4'd0, 24'h100000, 1'b1);
      i_px_valid = 1'b0;
      drainPx();

      // Last word coincides with the frame pulse: commit deferred
      startLoad(2'd1);
      sendWords(24'h200000, 0, 16, 1'b1, 1'b0);
      checkOutput("pendLate", 32'(o_pending), 32'h2);
      applyStimulus(2'd1, 4'd3, 24'h333333, 1'b0);
      i_px_valid = 1'b0;
      drainPx();
      pulseFrame();
      checkOutput("pendLateClr", 32'(o_pending), 32'd0);
      applyStimulus(2'd1, 4'd3, 24'h200003, 1'b0);
      i_px_valid = 1'b0;
      drainPx();

      // Restart onto palette 1 after 7 words of palette 3
      startLoad(2'd3);
      sendWords(24'h300000, 0, 7, 1'b0, 1'b0);
      checkOutput("pendPartial", 32'(o_pending), 32'd0);
      startLoad(2'd1);
      sendWords(24'h400000, 0, 15, 1'b0, 1'b0);
      checkOutput("busyRestart15", 32'(o_ld_busy), 32'd1);
      checkOutput("pendRestart15", 32'(o_pending), 32'd0);
      sendWords(24'h400000, 15, 1, 1'b0, 1'b0);
      checkOutput("busyRestart16", 32'(o_ld_busy), 32'd0);
      checkOutput("pendRestart16", 32'(o_pending), 32'h2);
      applyStimulus(2'd1, 4'd15, 24'h20000f, 1'b0);
      i_px_valid = 1'b0;
      drainPx();
      pulseFrame();
      checkOutput("pendRestartClr", 32'(o_pending), 32'd0);
      applyStimulus(2'd1, 4'd15, 24'h40000f, 1'b0);
      applyStimulus(2'd3, 4'd2, 24'h222222, 1'b0);
      i_px_valid = 1'b0;
      drainPx();

      // Back-to-back lookups while an unrelated palette loads with gaps
      fork
         begin
            for (int i = 0; i < 16; i++) begin
               applyStimulus(2'd2, 4'(i), 24'h100000 + 24'(i), (i == 0));
            end
            i_px_valid = 1'b0;
         end
         begin
            startLoad(2'd0);
            sendWords(24'h600000, 0, 16, 1'b0, 1'b1);
         end
      join
      drainPx();
      checkOutput("noBubble", 32'(lastRun), 32'd16);
      checkOutput("pendP0", 32'(o_pending), 32'h1);
      checkOutput("busyP0", 32'(o_ld_busy), 32'd0);

      // Reset in the middle of a load
      startLoad(2'd3);
      sendWords(24'h500000, 0, 5, 1'b0, 1'b0);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      i_rst_n = 1'b1;
      checkOutput("rstLdBusy", 32'(o_ld_busy), 32'd0);
      checkOutput("rstLdReady", 32'(o_ld_ready), 32'd0);
      checkOutput("rstLdPending", 32'(o_pending), 32'd0);
      checkOutput("rstLdPxValid", 32'(o_px_valid), 32'd0);
      checkOutput("rstLdRgb", 32'(o_rgb), 32'd0);
      for (int p = 0; p < 4; p++) begin
         applyStimulus(2'(p), 4'(p * 4 + 3), ramp(p * 4 + 3), 1'b0);
      end
      i_px_valid = 1'b0;
      drainPx();
      pulseFrame();
      applyStimulus(2'd0, 4'd7, ramp(7), 1'b0);
      applyStimulus(2'd3, 4'd4, ramp(4), 1'b0);
      i_px_valid = 1'b0;
      drainPx();

      $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
      $finish;
   end

endmodule

// File: doc/palette_lut.md
# palette_lut

Runtime-loadable, multi-palette colour lookup for the sprite/overlay decoders. It maps a pixel index to a 24-bit RGB value and a transparency flag. Each palette has a shadow copy that a loader fills word by word, and all pending shadows commit at the next frame boundary, so a scan-out never sees a partial palette. It sits between the sprite/caption decoders and the VGA compositor, and replaces fixed per-sprite palette tables.

## Interface
- `IDX_W`, 4, index width; each palette holds `2**IDX_W` entries.
- `COLOR_W`, 24, colour width, 8:8:8 RGB.
- `NUM_PAL`, 4, number of palettes. `PAL_W = $clog2(NUM_PAL)`, minimum 1.
- `TRANSP_EN`, 1, when 1, index 0 is reported transparent.

Ports:
- `i_clk`  in  1  the only clock.
- `i_rst_n`  in  1  synchronous reset, active-low.
- `i_ld_start`  in  1  one-cycle pulse that begins a load of palette `i_ld_pal`.
- `i_ld_pal`  in  PAL_W  target palette; sampled with `i_ld_start`.
- `i_ld_valid`  in  1  a load word is present.
- `i_ld_data`  in  COLOR_W  load word; words arrive in index order, starting at 0.
- `o_ld_ready`  out  1  the loader accepts a word.
- `o_ld_busy`  out  1  a load is in progress.
- `o_pending`  out  NUM_PAL  a shadow is complete and waiting to commit.
- `i_frame_start`  in  1  one-cycle pulse at the frame boundary; triggers commit.
- `i_px_valid`  in  1  a lookup request is present.
- `i_pal_sel`  in  PAL_W  palette for this lookup.
- `i_idx`  in  IDX_W  pixel index.
- `o_px_valid`  out  1  the lookup result is valid.
- `o_rgb`  out  COLOR_W  looked-up colour.
- `o_transparent`  out  1  index 0 and `TRANSP_EN` is set.

## Operation
- Storage: an `active[NUM_PAL][2**IDX_W]` array and a `shadow[NUM_PAL][2**IDX_W]` array, both in flops. The lookup path reads only `active`.
- Loader FSM has two states, IDLE and LOAD.
  - IDLE → LOAD on `i_ld_start`. Latch the target palette, clear the word counter, and clear `pending[pal]`.
  - In LOAD, `o_ld_ready` is 1. Each `i_ld_valid && o_ld_ready` writes `shadow[pal][cnt]` and increments `cnt`.
  - Acceptance of the word at `cnt == 2**IDX_W-1` → IDLE and sets `pending[pal]`.
  - `i_ld_start` while in LOAD restarts the load on the newly sampled palette at counter 0. It also sets `pending` for neither the old nor the new palette.
  - `i_ld_valid` while in IDLE is ignored; `o_ld_ready` is 0 in IDLE.
- Commit: on `i_frame_start`, every palette `p` whose registered `pending[p]` is 1 copies `shadow[p]` to `active[p]` and clears `pending[p]`. Palettes currently being loaded are never pending, so they are unaffected.
- Last word and `i_frame_start` in the same cycle: the commit uses the pre-edge `pending`. The new palette therefore waits for the next `i_frame_start`.
- Lookup: a two-stage pipeline.
  - Stage 1 registers valid, palette and index.
  - Stage 2 registers `active[pal][idx]`, the valid bit, and transparent = `TRANSP_EN && idx == 0`.
  - The pipeline has no stall: one result per request.
- `i_pal_sel >= NUM_PAL` when `NUM_PAL` is not a power of 2: output `o_rgb = 0` and `o_transparent = 1`.
- Reset state:
  - FSM in IDLE; `cnt = 0`; `pending = 0`.
  - Pipeline valid bits, `o_rgb` and `o_transparent` are 0.
  - `active` and `shadow` are initialised to a greyscale ramp: entry i = {3{8'(i * 255 / (2**IDX_W-1))}}.
- Reset during LOAD abandons the load. The shadow reverts to the ramp and `pending` is 0.

## Timing
- Lookup latency is 2 cycles: a request at edge t produces `o_px_valid` at t+2. Throughput is 1 per cycle.
- A request presented in the same cycle as `i_frame_start` sees the committed palette, because `active` updates at that edge and is read in stage 2.
- Loader throughput is 1 word per cycle. A full load takes `2**IDX_W` accepted beats after `i_ld_start`.
- `o_ld_busy` and `o_ld_ready` rise the cycle after `i_ld_start` and fall the cycle after the last word is accepted.
- `o_pending[p]` rises the cycle after the last word and falls the cycle after the committing `i_frame_start`.

## Structure
- A shared package `palette_pkg` holds:
  - `rgb_t` (COLOR_W packed);
  - the FSM state enum `ld_state_e` {LD_IDLE, LD_LOAD};
  - the function `grey_ramp(i, IDX_W)` used for reset contents.
- One sub-module, `palette_loader`, holds the FSM, the counter and `pending`. It drives shadow write-enable, address, palette and data. The top level holds the arrays, the commit logic and the lookup pipeline.

## Test plan
- Reset, then look up palette 0, idx 15 and idx 0 (defaults) → `o_rgb` = 24'hffffff then 24'h000000 with `o_transparent` = 1, each two cycles after its request.
- Load palette 2 with words 24'h100000 + i, then look up palette 2, idx 5 before `i_frame_start` → ramp value 24'h555555. After `i_frame_start` → 24'h100005; `o_pending[2]` clears.
- Last load word accepted in the same cycle as `i_frame_start` → no commit. The next `i_frame_start` commits.
- `i_ld_start` for palette 1 mid-way through a palette 3 load (after 7 words) → palette 3 is never pending, and palette 1 needs 16 fresh words.
- `i_rst_n` = 0 for one cycle during a load → `o_ld_busy` = 0, `o_pending` = 0, and all palettes read back the ramp.
- Back-to-back lookups of 16 indices with `i_ld_valid` toggling randomly on an unrelated palette → 16 consecutive correct outputs with no bubbles.
